// File: rtl/hazard_unit_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// result-source encoding and the memory-wait FSM state.
package hazard_unit_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_t;

    localparam logic [1:0] RESULT_LOAD = 2'b01;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } hz_state_t;

    // x0 is hardwired zero, so a write to it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != '0) && (rd == rs);
    endfunction

endpackage

// File: rtl/hazard_unit_if.sv
// Pipeline <-> hazard unit signal bundle. The pipeline side is the master,
// the hazard unit the slave.
interface hazard_unit_if #(
    parameter int unsigned CNT_W = 32
);
    import hazard_unit_pkg::*;

    logic [4:0]       Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic [1:0]       ResultSrcE;
    logic             RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM;
    fwd_sel_t         ForwardAE, ForwardBE;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW, MemErr;
    logic [CNT_W-1:0] StallCycles;

    modport master (
        output Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, MemErr, StallCycles
    );

    modport slave (
        input  Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW, ResultSrcE,
               RegWriteM, RegWriteW, PCSrcE, MemReqM, MemReadyM,
        output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
               FlushD, FlushE, FlushW, MemErr, StallCycles
    );

endinterface

// File: rtl/hazard_unit_fwd_sel.sv
// Forwarding select for one Execute operand; the M-stage result is newer
// than the W-stage result and therefore takes priority.
module fwd_sel
    import hazard_unit_pkg::*;
(
    input  logic [4:0] RsE_i,
    input  logic [4:0] RdM_i,
    input  logic [4:0] RdW_i,
    input  logic       RegWriteM_i,
    input  logic       RegWriteW_i,
    output fwd_sel_t   Fwd_o
);

    always_comb begin
        Fwd_o = FWD_RF;
        if (RegWriteM_i && reg_match(RdM_i, RsE_i)) begin
            Fwd_o = FWD_M;
        end else if (RegWriteW_i && reg_match(RdW_i, RsE_i)) begin
            Fwd_o = FWD_W;
        end
    end

endmodule

// File: rtl/hazard_unit.sv
// Hazard controller for the 5-stage core: operand forwarding, load-use and
// branch handling, and a data-memory wait FSM with timeout.
module hazard_unit
    import hazard_unit_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned CNT_W       = 32
) (
    input  logic         clk,
    input  logic         rst,
    hazard_unit_if.slave hz
);

    localparam int unsigned WAIT_W = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    hz_state_t         state_q, state_d;
    logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;

    fwd_sel_t fwd_a, fwd_b;
    logic     load_use;
    logic     stall_f, stall_d, stall_e, stall_m;
    logic     flush_d, flush_e, flush_w, mem_err;

    fwd_sel u_fwd_a (
        .RsE_i       (hz.Rs1E),
        .RdM_i       (hz.RdM),
        .RdW_i       (hz.RdW),
        .RegWriteM_i (hz.RegWriteM),
        .RegWriteW_i (hz.RegWriteW),
        .Fwd_o       (fwd_a)
    );

    fwd_sel u_fwd_b (
        .RsE_i       (hz.Rs2E),
        .RdM_i       (hz.RdM),
        .RdW_i       (hz.RdW),
        .RegWriteM_i (hz.RegWriteM),
        .RegWriteW_i (hz.RegWriteW),
        .Fwd_o       (fwd_b)
    );

    assign load_use = (hz.ResultSrcE == RESULT_LOAD) &&
                      (reg_match(hz.RdE, hz.Rs1D) || reg_match(hz.RdE, hz.Rs2D));

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        stall_f    = 1'b0;
        stall_d    = 1'b0;
        stall_e    = 1'b0;
        stall_m    = 1'b0;
        flush_d    = 1'b0;
        flush_e    = 1'b0;
        flush_w    = 1'b0;
        mem_err    = 1'b0;
        unique case (state_q)
            RUN: begin
                if (hz.MemReqM && !hz.MemReadyM) begin
                    state_d = MEM_WAIT;
                    {stall_f, stall_d, stall_e, stall_m} = '1;
                    flush_w = 1'b1;
                end else if (hz.PCSrcE) begin
                    flush_d = 1'b1;
                    flush_e = 1'b1;
                end else if (load_use) begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    flush_e = 1'b1;
                end
            end
            MEM_WAIT: begin
                // Branches are ignored here: E is frozen and re-presents on release.
                if (hz.MemReadyM) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                end else if (wait_cnt_q == WAIT_LAST) begin
                    state_d    = RUN;
                    wait_cnt_d = '0;
                    flush_w    = 1'b1;
                    mem_err    = 1'b1;
                end else begin
                    {stall_f, stall_d, stall_e, stall_m} = '1;
                    flush_w    = 1'b1;
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
            end
            default: state_d = RUN;
        endcase
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (stall_f && (stall_cnt_q != '1)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= RUN;
            wait_cnt_q  <= '0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            wait_cnt_q  <= wait_cnt_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // While reset is held the pipeline is flushed and nothing stalls or forwards.
    assign hz.ForwardAE   = rst ? FWD_RF : fwd_a;
    assign hz.ForwardBE   = rst ? FWD_RF : fwd_b;
    assign hz.StallF      = stall_f & ~rst;
    assign hz.StallD      = stall_d & ~rst;
    assign hz.StallE      = stall_e & ~rst;
    assign hz.StallM      = stall_m & ~rst;
    assign hz.FlushD      = flush_d | rst;
    assign hz.FlushE      = flush_e | rst;
    assign hz.FlushW      = flush_w | rst;
    assign hz.MemErr      = mem_err & ~rst;
    assign hz.StallCycles = stall_cnt_q;

endmodule
